// File: rtl/centroid_bbox.sv
// centroid_bbox: per-frame mask area and centroid engine with a serial divider.
// Accumulates m00/m10/m01 over mask pixels, divides m10/m00 and m01/m00 with a
// restoring divider and publishes results gated on a minimum area.
// Optional bounding-box tracking is enabled with the CENTROID_BBOX_EN macro.
`timescale 1ns/1ps
module centroid_bbox #(
  parameter int unsigned IMG_W    = 720,
  parameter int unsigned IMG_H    = 576,
  parameter int unsigned CW       = 10,
  parameter int unsigned AW       = 30,
  parameter int unsigned MIN_AREA = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          de,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          mask,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [AW-1:0] area,
  output logic          valid,
  output logic          result_stb,
  output logic          busy,
  output logic          overrun,
  output logic [CW-1:0] c_w,
  output logic [CW-1:0] c_h
`ifdef CENTROID_BBOX_EN
  ,
  output logic [CW-1:0] x_min,
  output logic [CW-1:0] x_max,
  output logic [CW-1:0] y_min,
  output logic [CW-1:0] y_max
`endif
);

  localparam int unsigned   CNT_W     = (AW > 1) ? $clog2(AW) : 1;
  localparam logic [CW-1:0] W_LAST    = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_LAST    = CW'(IMG_H - 1);
  localparam logic [AW-1:0] W_LAST_AW = AW'(IMG_W - 1);
  localparam logic [AW-1:0] H_LAST_AW = AW'(IMG_H - 1);
  localparam logic [AW-1:0] MIN_A     = AW'(MIN_AREA);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state, state_nx;
  logic             prev_vsync;
  logic             eof, acc_en, take, go_div, last;
  logic [AW-1:0]    m00, m10, m01;
  logic [AW-1:0]    rx, qx, ry, qy, dvs;
  logic [CNT_W-1:0] cnt;
  logic [2*AW-1:0]  stx, sty;
  logic             unused_hsync;

  assign unused_hsync = hsync;

  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AW] ? '1 : s[AW-1:0];
  endfunction

  // One restoring-division step: returns {remainder, quotient-shift-register}.
  function automatic logic [2*AW-1:0] div_step(input logic [AW-1:0] r, input logic [AW-1:0] q,
                                               input logic [AW-1:0] d);
    logic [AW:0] sh;
    sh = {r, q[AW-1]};
    if (sh >= {1'b0, d}) begin
      sh = sh - {1'b0, d};
      return {sh[AW-1:0], q[AW-2:0], 1'b1};
    end
    return {sh[AW-1:0], q[AW-2:0], 1'b0};
  endfunction

  function automatic logic [CW-1:0] clamp(input logic [AW-1:0] q, input logic [AW-1:0] lim);
    return (q > lim) ? lim[CW-1:0] : q[CW-1:0];
  endfunction

  assign eof    = ce & prev_vsync & ~vsync;
  assign acc_en = ce & vsync & de & mask;
  assign take   = eof && (state == IDLE);
  assign go_div = take && (m00 >= MIN_A) && (m00 != '0);
  assign last   = (state == DIV) && (cnt == CNT_W'(AW - 1));

  // Raster position counters, cleared outside the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_w <= '0;
      c_h <= '0;
    end else if (ce) begin
      if (!vsync) begin
        c_w <= '0;
        c_h <= '0;
      end else if (de) begin
        if (c_w == W_LAST) begin
          c_w <= '0;
          c_h <= (c_h == H_LAST) ? '0 : c_h + 1'b1;
        end else begin
          c_w <= c_w + 1'b1;
        end
      end
    end
  end

  // Delayed vsync for end-of-frame edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_vsync <= 1'b0;
    else if (ce) prev_vsync <= vsync;
  end

  // Moment accumulators: cleared at every eof, even when the frame is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m00 <= '0;
      m10 <= '0;
      m01 <= '0;
    end else if (eof) begin
      m00 <= '0;
      m10 <= '0;
      m01 <= '0;
    end else if (acc_en) begin
      m00 <= sat_add(m00, AW'(1));
      m10 <= sat_add(m10, AW'(c_w));
      m01 <= sat_add(m01, AW'(c_h));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next state and status outputs.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    result_stb = 1'b0;
    case (state)
      IDLE: if (take) state_nx = go_div ? DIV : DONE;
      DIV: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        result_stb = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Divider step results for x and y.
  always_comb begin
    stx = div_step(rx, qx, dvs);
    sty = div_step(ry, qy, dvs);
  end

  // Divider datapath: loaded straight from the accumulators in the eof cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx  <= '0;
      qx  <= '0;
      ry  <= '0;
      qy  <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (go_div) begin
      rx  <= '0;
      qx  <= m10;
      ry  <= '0;
      qy  <= m01;
      dvs <= m00;
      cnt <= '0;
    end else if (state == DIV) begin
      rx  <= stx[2*AW-1:AW];
      qx  <= stx[AW-1:0];
      ry  <= sty[2*AW-1:AW];
      qy  <= sty[AW-1:0];
      cnt <= cnt + 1'b1;
    end
  end

  // Result registers: written on the transition into DONE so they are valid with result_stb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      area    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= eof && (state != IDLE);
      if (take && !go_div) begin
        area  <= m00;
        valid <= 1'b0;
      end else if (last) begin
        area  <= dvs;
        valid <= 1'b1;
        x     <= clamp(stx[AW-1:0], W_LAST_AW);
        y     <= clamp(sty[AW-1:0], H_LAST_AW);
      end
    end
  end

`ifdef CENTROID_BBOX_EN
  logic [CW-1:0] bx_lo, bx_hi, by_lo, by_hi;
  logic [CW-1:0] sx_lo, sx_hi, sy_lo, sy_hi;

  // Running per-frame bounding box; reinitialised at every eof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx_lo <= '1;
      bx_hi <= '0;
      by_lo <= '1;
      by_hi <= '0;
    end else if (eof) begin
      bx_lo <= '1;
      bx_hi <= '0;
      by_lo <= '1;
      by_hi <= '0;
    end else if (acc_en) begin
      if (c_w < bx_lo) bx_lo <= c_w;
      if (c_w > bx_hi) bx_hi <= c_w;
      if (c_h < by_lo) by_lo <= c_h;
      if (c_h > by_hi) by_hi <= c_h;
    end
  end

  // Snapshot at accepted eof; publish only alongside a valid centroid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_lo <= '0;
      sx_hi <= '0;
      sy_lo <= '0;
      sy_hi <= '0;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
    end else begin
      if (go_div) begin
        sx_lo <= bx_lo;
        sx_hi <= bx_hi;
        sy_lo <= by_lo;
        sy_hi <= by_hi;
      end
      if (last) begin
        x_min <= sx_lo;
        x_max <= sx_hi;
        y_min <= sy_lo;
        y_max <= sy_hi;
      end
    end
  end
`endif

endmodule

// File: tb/tb_centroid_bbox.sv
// Testbench for centroid_bbox on a reduced 16x8 raster with MIN_AREA=4.
`timescale 1ns/1ps
module tb_centroid_bbox;
  localparam int unsigned W = 16, H = 8, CW = 5, AW = 16, MINA = 4;

  logic clk = 1'b0;
  logic rst_n, ce, de, hsync, vsync, mask;
  logic [CW-1:0] x, y, c_w, c_h;
  logic [AW-1:0] area;
  logic valid, result_stb, busy, overrun;
`ifdef CENTROID_BBOX_EN
  logic [CW-1:0] x_min, x_max, y_min, y_max;
`endif

  centroid_bbox #(.IMG_W(W), .IMG_H(H), .CW(CW), .AW(AW), .MIN_AREA(MINA)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .de(de), .hsync(hsync), .vsync(vsync), .mask(mask),
    .x(x), .y(y), .area(area), .valid(valid), .result_stb(result_stb), .busy(busy),
    .overrun(overrun), .c_w(c_w), .c_h(c_h)
`ifdef CENTROID_BBOX_EN
    , .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] area;
    logic          valid;
    logic [CW-1:0] x, y;
    int unsigned   lat;
    logic [CW-1:0] xmin, xmax, ymin, ymax;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic [CW-1:0] hold_x = '0, hold_y = '0;
  logic [CW-1:0] hold_xmin = '0, hold_xmax = '0, hold_ymin = '0, hold_ymax = '0;
  int unsigned t_eof;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic mask_at(input int kind, input int c, input int r);
    case (kind)
      0:       return 1'b0;
      1:       return (c == 3 || c == 4) && (r == 1 || r == 2);
      2:       return 1'b1;
      3:       return (r == 5) && (c >= 10) && (c <= 12);
      default: return c == r + 5;
    endcase
  endfunction

  // Drives one frame, builds the expectation from the mask and pushes it at eof.
  task automatic drive_frame(input int kind, input bit gaps);
    int m00 = 0, m10 = 0, m01 = 0, xl = W, xh = 0, yl = H, yh = 0;
    exp_t e;
    ce = 1; de = 0; mask = 0; vsync = 1;
    tick; tick;
    for (int r = 0; r < int'(H); r++) begin
      n_cmp++;
      if (c_w !== '0 || c_h !== CW'(r)) begin
        n_bad++;
        $display("FAIL line_start r=%0d: c_w=%0d c_h=%0d, expected 0/%0d", r, c_w, c_h, r);
      end
      for (int c = 0; c < int'(W); c++) begin
        if (gaps && c == 5) begin
          ce = 0; de = 1; mask = 1;
          tick; tick;
          n_cmp++;
          if (c_w !== CW'(5) || c_h !== CW'(r)) begin
            n_bad++;
            $display("FAIL ce_freeze r=%0d: c_w=%0d c_h=%0d, expected 5/%0d", r, c_w, c_h, r);
          end
        end
        ce = 1; de = 1; mask = mask_at(kind, c, r);
        if (mask) begin
          m00++; m10 += c; m01 += r;
          if (c < xl) xl = c;
          if (c > xh) xh = c;
          if (r < yl) yl = r;
          if (r > yh) yh = r;
        end
        tick;
      end
      de = 0; mask = 0;
      tick;
    end
    n_cmp++;
    if (c_w !== '0 || c_h !== '0) begin
      n_bad++;
      $display("FAIL frame_wrap: c_w=%0d c_h=%0d, expected 0/0", c_w, c_h);
    end
    e.area = AW'(m00);
    if (m00 >= int'(MINA) && m00 != 0) begin
      e.valid = 1'b1;
      e.x = CW'((m10 / m00 > int'(W) - 1) ? int'(W) - 1 : m10 / m00);
      e.y = CW'((m01 / m00 > int'(H) - 1) ? int'(H) - 1 : m01 / m00);
      e.lat = AW + 1;
      hold_x = e.x; hold_y = e.y;
      hold_xmin = CW'(xl); hold_xmax = CW'(xh); hold_ymin = CW'(yl); hold_ymax = CW'(yh);
    end else begin
      e.valid = 1'b0;
      e.x = hold_x; e.y = hold_y;
      e.lat = 1;
    end
    e.xmin = hold_xmin; e.xmax = hold_xmax; e.ymin = hold_ymin; e.ymax = hold_ymax;
    vsync = 0;
    t_eof = cyc;
    sb.push_back(e);
  endtask

  // Waits (bounded) for result_stb; reports only observations.
  task automatic collect(output bit got, output int unsigned at, output bit saw_busy);
    got = 0; at = 0; saw_busy = 0;
    for (int i = 0; i < int'(AW) + 10 && !got; i++) begin
      tick;
      if (busy) saw_busy = 1;
      if (result_stb) begin
        got = 1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0; ce = 0; de = 0; hsync = 0; vsync = 0; mask = 0;
    tick; tick; tick;
    n_cmp++;
    if ({x, y, area, valid, result_stb, busy, overrun, c_w, c_h} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: x=%0d y=%0d area=%0d valid=%b stb=%b busy=%b ovr=%b c_w=%0d c_h=%0d, expected all 0",
               x, y, area, valid, result_stb, busy, overrun, c_w, c_h);
    end
    rst_n = 1;
    tick;
  endtask

  // Runs one frame and checks the single resulting strobe against the scoreboard.
  task automatic test_frame(input string name, input int kind, input bit gaps);
    bit got, saw_busy;
    int unsigned at;
    exp_t e;
    drive_frame(kind, gaps);
    collect(got, at, saw_busy);
    e = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s_timeout: result_stb not seen within %0d cycles", name, AW + 10);
    end
    n_cmp++;
    if (at !== t_eof + e.lat) begin
      n_bad++;
      $display("FAIL %s_latency: stb at cycle %0d, expected %0d", name, at, t_eof + e.lat);
    end
    n_cmp++;
    if (area !== e.area || valid !== e.valid || x !== e.x || y !== e.y) begin
      n_bad++;
      $display("FAIL %s_result: area=%0d valid=%b x=%0d y=%0d, expected %0d %b %0d %0d",
               name, area, valid, x, y, e.area, e.valid, e.x, e.y);
    end
    if (!e.valid) begin
      n_cmp++;
      if (saw_busy) begin
        n_bad++;
        $display("FAIL %s_busy: busy=1 seen, expected 0 for sub-threshold area", name);
      end
    end
`ifdef CENTROID_BBOX_EN
    n_cmp++;
    if (x_min !== e.xmin || x_max !== e.xmax || y_min !== e.ymin || y_max !== e.ymax) begin
      n_bad++;
      $display("FAIL %s_bbox: %0d..%0d/%0d..%0d, expected %0d..%0d/%0d..%0d",
               name, x_min, x_max, y_min, y_max, e.xmin, e.xmax, e.ymin, e.ymax);
    end
`endif
  endtask

  task automatic test_overrun;
    int n_stb = 0, n_ovr = 0;
    int unsigned t1, t2, stb_at = 0, ovr_at = 0;
    exp_t e;
    drive_frame(1, 0);
    t1 = t_eof;
    e = sb.pop_front();
    tick;
    vsync = 1; de = 1; mask = 1;
    tick; tick; tick; tick;
    vsync = 0; de = 0; mask = 0;
    t2 = cyc;
    for (int i = 0; i < int'(AW) + 10; i++) begin
      tick;
      if (result_stb) begin n_stb++; stb_at = cyc; end
      if (overrun) begin n_ovr++; ovr_at = cyc; end
    end
    n_cmp++;
    if (n_stb != 1 || stb_at != t1 + AW + 1) begin
      n_bad++;
      $display("FAIL ovr_stb: %0d strobes, last at %0d, expected 1 at %0d", n_stb, stb_at, t1 + AW + 1);
    end
    n_cmp++;
    if (n_ovr != 1 || ovr_at != t2 + 1) begin
      n_bad++;
      $display("FAIL ovr_pulse: %0d pulses, last at %0d, expected 1 at %0d", n_ovr, ovr_at, t2 + 1);
    end
    n_cmp++;
    if (area !== e.area || valid !== e.valid || x !== e.x || y !== e.y) begin
      n_bad++;
      $display("FAIL ovr_result: area=%0d valid=%b x=%0d y=%0d, expected %0d %b %0d %0d",
               area, valid, x, y, e.area, e.valid, e.x, e.y);
    end
    test_frame("post_ovr", 2, 0);
  endtask

  task automatic test_reset_mid_div;
    int n_stb = 0;
    exp_t e;
    drive_frame(2, 0);
    e = sb.pop_front();
    tick; tick; tick; tick; tick;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL div_busy: busy=%b, expected 1", busy);
    end
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({x, y, area, valid, result_stb, busy, overrun, c_w, c_h} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: x=%0d y=%0d area=%0d valid=%b stb=%b busy=%b ovr=%b, expected all 0",
               x, y, area, valid, result_stb, busy, overrun);
    end
    tick; tick;
    rst_n = 1;
    hold_x = '0; hold_y = '0;
    hold_xmin = '0; hold_xmax = '0; hold_ymin = '0; hold_ymax = '0;
    for (int i = 0; i < int'(AW) + 5; i++) begin
      tick;
      if (result_stb) n_stb++;
    end
    n_cmp++;
    if (n_stb != 0) begin
      n_bad++;
      $display("FAIL abort_no_stb: %0d strobes after reset, expected 0", n_stb);
    end
    test_frame("after_reset", 1, 0);
  endtask

  initial begin
    test_reset;
    test_frame("blob", 1, 0);
    test_frame("full", 2, 0);
    test_frame("empty", 0, 0);
    test_frame("small", 3, 0);
    test_overrun;
    test_frame("ce_gaps", 4, 1);
    test_reset_mid_div;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
